atm_multi_account_ctrl: RTL

// - Next-generation ATM session controller: N accounts, per-account PIN and balance,

---
 rtl/atm_multi_account_ctrl_pkg.sv | 28 ++
 rtl/atm_multi_account_ctrl_if.sv | 37 +++
 rtl/atm_multi_account_ctrl_bank.sv | 52 +++++
 rtl/atm_multi_account_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/atm_multi_account_ctrl_pkg.sv
// Shared encodings for the multi-account ATM controller: FSM states,
// error codes and menu operation codes.
package atm_multi_account_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LANG  = 3'd1,
    S_PIN   = 3'd2,
    S_MENU  = 3'd3,
    S_WD    = 3'd4,
    S_DEP   = 3'd5,
    S_BAL   = 3'd6,
    S_EJECT = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_PIN   = 2'd1,
    ERR_FUNDS = 2'd2,
    ERR_LOCK  = 2'd3   // also used for deposit saturation
  } err_e;

  localparam logic [1:0] OP_WD   = 2'd0;
  localparam logic [1:0] OP_DEP  = 2'd1;
  localparam logic [1:0] OP_BAL  = 2'd2;
  localparam logic [1:0] OP_EXIT = 2'd3;

endpackage

// File: rtl/atm_multi_account_ctrl_if.sv
// Front-end <-> controller bundle: card/keypad requests in, display status out.
interface atm_multi_account_ctrl_if #(
  parameter int NUM_ACCTS = 4,
  parameter int BAL_W     = 8,
  parameter int AMT_W     = 6,
  parameter int PIN_W     = 4
);
  localparam int AW = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;

  logic             card_in;
  logic [AW-1:0]    acct_id;
  logic             lang_sel;
  logic [PIN_W-1:0] pin;
  logic             pin_valid;
  logic [1:0]       op;
  logic             op_valid;
  logic [AMT_W-1:0] amount;
  logic             go_main;
  logic [BAL_W-1:0] cur_balance;
  logic [BAL_W-1:0] final_balance;
  logic [2:0]       state_o;
  logic [1:0]       err_o;
  logic             op_done;
  logic             card_eject;

  // front end side
  modport master (
    output card_in, acct_id, lang_sel, pin, pin_valid, op, op_valid, amount, go_main,
    input  cur_balance, final_balance, state_o, err_o, op_done, card_eject
  );

  // controller side
  modport slave (
    input  card_in, acct_id, lang_sel, pin, pin_valid, op, op_valid, amount, go_main,
    output cur_balance, final_balance, state_o, err_o, op_done, card_eject
  );
endinterface

// File: rtl/atm_multi_account_ctrl_bank.sv
// Per-account storage: balance, PIN, wrong-PIN try counter and lock bit.
// One combinational read port, one write port (balance/tries/lock), lock
// bits of every account exported so a card can be screened before latching.
module atm_account_bank #(
  parameter int               NUM_ACCTS   = 4,
  parameter int               BAL_W       = 8,
  parameter int               PIN_W       = 4,
  parameter int               TRW         = 2,
  parameter logic [PIN_W-1:0] DEFAULT_PIN = 'hD,
  parameter logic [BAL_W-1:0] INIT_BAL    = 'd100,
  localparam int              AW          = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        rd_idx,
  output logic [BAL_W-1:0]     rd_bal,
  output logic [PIN_W-1:0]     rd_pin,
  output logic [TRW-1:0]       rd_tries,
  output logic [NUM_ACCTS-1:0] locked,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_idx,
  input  logic [BAL_W-1:0]     wr_bal,
  input  logic [TRW-1:0]       wr_tries,
  input  logic                 wr_lock
);
  logic [NUM_ACCTS-1:0][BAL_W-1:0] bal_q;
  logic [NUM_ACCTS-1:0][PIN_W-1:0] pin_q;
  logic [NUM_ACCTS-1:0][TRW-1:0]   tries_q;
  logic [NUM_ACCTS-1:0]            lock_q;

  // account array: reset to defaults, single indexed write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal_q[i]   <= INIT_BAL;
        pin_q[i]   <= DEFAULT_PIN;
        tries_q[i] <= '0;
        lock_q[i]  <= 1'b0;
      end
    end else if (wr_en) begin
      bal_q[wr_idx]   <= wr_bal;
      tries_q[wr_idx] <= wr_tries;
      lock_q[wr_idx]  <= wr_lock;
    end
  end

  assign rd_bal   = bal_q[rd_idx];
  assign rd_pin   = pin_q[rd_idx];
  assign rd_tries = tries_q[rd_idx];
  assign locked   = lock_q;

endmodule

// File: rtl/atm_multi_account_ctrl.sv
// ATM session controller for NUM_ACCTS accounts: language/PIN/menu flow,
// wrong-PIN lockout, inactivity timeout, withdraw with funds check and
// saturating deposit. Account state lives in atm_account_bank.
module atm_multi_account_ctrl
  import atm_multi_account_ctrl_pkg::*;
#(
  parameter int               NUM_ACCTS   = 4,
  parameter int               BAL_W       = 8,
  parameter int               AMT_W       = 6,
  parameter int               PIN_W       = 4,
  parameter logic [PIN_W-1:0] DEFAULT_PIN = 'hD,
  parameter logic [BAL_W-1:0] INIT_BAL    = 'd100,
  parameter int               MAX_TRIES   = 3,
  parameter int               TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  atm_multi_account_ctrl_if.slave bus
);
  localparam int AW  = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
  localparam int TRW = $clog2(MAX_TRIES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_n;
  err_e               err_q, err_n;
  logic [AW-1:0]      acct_q, acct_n;
  logic [TW-1:0]      tmo_q, tmo_n;
  logic               done_q, done_n;
  logic [BAL_W-1:0]   fb_q, fb_n;

  logic [BAL_W-1:0]     rd_bal, wr_bal, amt_ext;
  logic [PIN_W-1:0]     rd_pin;
  logic [TRW-1:0]       rd_tries, wr_tries;
  logic [NUM_ACCTS-1:0] locked;
  logic                 wr_en, wr_lock;
  logic [BAL_W:0]       sum;
  logic                 any_vld, session, tmo_hit;

  atm_account_bank #(
    .NUM_ACCTS(NUM_ACCTS), .BAL_W(BAL_W), .PIN_W(PIN_W), .TRW(TRW),
    .DEFAULT_PIN(DEFAULT_PIN), .INIT_BAL(INIT_BAL)
  ) u_bank (
    .clk(clk), .rst(rst),
    .rd_idx(acct_q), .rd_bal(rd_bal), .rd_pin(rd_pin), .rd_tries(rd_tries),
    .locked(locked),
    .wr_en(wr_en), .wr_idx(acct_q), .wr_bal(wr_bal), .wr_tries(wr_tries),
    .wr_lock(wr_lock)
  );

  assign amt_ext = BAL_W'(bus.amount);
  assign sum     = (BAL_W+1)'(rd_bal) + (BAL_W+1)'(bus.amount);
  assign any_vld = bus.lang_sel | bus.pin_valid | bus.op_valid | bus.go_main;
  assign session = state_q inside {S_LANG, S_PIN, S_MENU, S_WD, S_DEP, S_BAL};
  // the TIMEOUT_CYC-th idle cycle in a session state forces eject
  assign tmo_hit = session && (tmo_q == TW'(TIMEOUT_CYC - 1));

  // session registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      acct_q  <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      fb_q    <= '0;
    end else begin
      state_q <= state_n;
      err_q   <= err_n;
      acct_q  <= acct_n;
      tmo_q   <= tmo_n;
      done_q  <= done_n;
      fb_q    <= fb_n;
    end
  end

  // next state, error, commit and bank write
  always_comb begin
    state_n  = state_q;
    err_n    = any_vld ? ERR_NONE : err_q;
    acct_n   = acct_q;
    done_n   = 1'b0;
    fb_n     = fb_q;
    wr_en    = 1'b0;
    wr_bal   = rd_bal;
    wr_tries = rd_tries;
    wr_lock  = locked[acct_q];

    if (session && !bus.card_in) begin
      state_n = S_EJECT;                        // card pulled: abort, no commit
    end else if (tmo_hit) begin
      state_n = S_EJECT;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.card_in) begin
          acct_n = bus.acct_id;
          if (locked[bus.acct_id]) begin
            state_n = S_EJECT;
            err_n   = ERR_LOCK;
          end else begin
            state_n = S_LANG;
          end
        end
        S_LANG: if (bus.lang_sel) state_n = S_PIN;
        S_PIN: if (bus.pin_valid) begin
          wr_en = 1'b1;
          if (bus.pin == rd_pin) begin
            wr_tries = '0;
            state_n  = S_MENU;
            err_n    = ERR_NONE;
          end else if (rd_tries == TRW'(MAX_TRIES - 1)) begin
            wr_tries = rd_tries + TRW'(1);
            wr_lock  = 1'b1;
            state_n  = S_EJECT;
            err_n    = ERR_LOCK;
          end else begin
            wr_tries = rd_tries + TRW'(1);
            err_n    = ERR_PIN;
          end
        end
        S_MENU: if (bus.op_valid) begin
          unique case (bus.op)
            OP_WD:   state_n = S_WD;
            OP_DEP:  state_n = S_DEP;
            OP_BAL:  state_n = S_BAL;
            default: state_n = S_EJECT;
          endcase
        end
        S_WD: if (bus.go_main) begin
          state_n = S_MENU;
          err_n   = ERR_NONE;
        end else if (bus.op_valid) begin
          if (amt_ext <= rd_bal) begin
            wr_en   = 1'b1;
            wr_bal  = rd_bal - amt_ext;
            fb_n    = rd_bal - amt_ext;
            done_n  = 1'b1;
            state_n = S_MENU;
            err_n   = ERR_NONE;
          end else begin
            err_n = ERR_FUNDS;
          end
        end
        S_DEP: if (bus.go_main) begin
          state_n = S_MENU;
          err_n   = ERR_NONE;
        end else if (bus.op_valid) begin
          wr_en   = 1'b1;
          wr_bal  = sum[BAL_W] ? '1 : sum[BAL_W-1:0];
          fb_n    = sum[BAL_W] ? '1 : sum[BAL_W-1:0];
          done_n  = 1'b1;
          state_n = S_MENU;
          err_n   = sum[BAL_W] ? ERR_LOCK : ERR_NONE;
        end
        S_BAL: begin
          fb_n    = rd_bal;
          done_n  = 1'b1;
          state_n = S_MENU;
          err_n   = ERR_NONE;
        end
        S_EJECT: if (!bus.card_in) begin
          state_n = S_IDLE;
          err_n   = ERR_NONE;
        end
        default: state_n = S_IDLE;
      endcase
    end

    // idle counter restarts on activity or any state change
    if (any_vld || state_n != state_q || !session) tmo_n = '0;
    else                                          tmo_n = tmo_q + TW'(1);
  end

  assign bus.cur_balance   = rd_bal;
  assign bus.final_balance = fb_q;
  assign bus.state_o       = state_q;
  assign bus.err_o         = err_q;
  assign bus.op_done       = done_q;
  assign bus.card_eject    = (state_q == S_EJECT);

endmodule
